// File: rtl/adc_pattern_monitor.sv
// rtl/adc_pattern_monitor.sv - ADC test-pattern checker (ramp / fixed) with error statistics
//
// Checks a stream of multi-lane ADC words against either a ramp (each sample is
// the previous one plus a step, continuing across words) or a fixed pattern, over
// a window of accepted words, and reports error count, per-lane sticky flags, the
// index of the first bad word, and a pass flag.
//
// Ports:
//   clk               sole clock
//   rst               asynchronous active-high reset
//   data_valid_i      qualifies adc_data_i
//   adc_data_i        LANES samples, lane i at [(i+1)*W-1:i*W], lane 0 oldest
//   mode_i            0 = ramp, 1 = fixed pattern (latched at start)
//   step_i            ramp increment (latched at start)
//   pattern_i         fixed pattern value (latched at start)
//   start_i           test request, honoured only when idle
//   abort_i           cancels a running test
//   window_len_i      accepted words per test, 0 behaves as 1 (latched at start)
//   busy_o            test in progress (RUN/DRAIN)
//   done_o            one-cycle completion pulse
//   pass_o            set with done_o when no errors were seen
//   err_cnt_o         saturating count of erroring lanes
//   lane_err_mask_o   sticky per-lane error flags
//   first_err_word_o  0-based index of the first accepted word with an error

module adc_pattern_monitor #(
    parameter int ADC_DATA_WIDTH    = 8,
    parameter int PARALLEL_PATH_NUM = 4,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           data_valid_i,
    input  logic [ADC_DATA_WIDTH*2*PARALLEL_PATH_NUM-1:0]  adc_data_i,
    input  logic                                           mode_i,
    input  logic [ADC_DATA_WIDTH-1:0]                      step_i,
    input  logic [ADC_DATA_WIDTH-1:0]                      pattern_i,
    input  logic                                           start_i,
    input  logic                                           abort_i,
    input  logic [CNT_WIDTH-1:0]                           window_len_i,
    output logic                                           busy_o,
    output logic                                           done_o,
    output logic                                           pass_o,
    output logic [CNT_WIDTH-1:0]                           err_cnt_o,
    output logic [2*PARALLEL_PATH_NUM-1:0]                 lane_err_mask_o,
    output logic [CNT_WIDTH-1:0]                           first_err_word_o
);

    localparam int W     = ADC_DATA_WIDTH;
    localparam int LANES = 2 * PARALLEL_PATH_NUM;
    localparam int PCW   = $clog2(LANES + 1);
    localparam int SUMW  = CNT_WIDTH + PCW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;

    // Test configuration captured at start
    logic                 mode_q;
    logic [W-1:0]         step_q;
    logic [W-1:0]         pattern_q;
    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] word_cnt;
    logic                 drain_cnt;

    // Ramp continuity across words: last lane of the most recent accepted word
    logic [W-1:0]         last_lane;
    logic                 have_prev;

    // Stage 1: input register
    logic                 s1_valid;
    logic [W*LANES-1:0]   s1_data;
    logic [CNT_WIDTH-1:0] s1_idx;
    logic [W-1:0]         s1_prev_last;
    logic                 s1_has_prev;

    // Stage 2: per-lane compare result
    logic                 s2_valid;
    logic [LANES-1:0]     s2_err;
    logic [CNT_WIDTH-1:0] s2_idx;

    // Stage 3 bookkeeping
    logic                 found;

    logic                 accept;
    logic [W*LANES-1:0]   prev_vec;
    logic [LANES-1:0]     lane_err;
    logic [PCW-1:0]       pop;
    logic [SUMW-1:0]      sum_ext;
    logic [CNT_WIDTH-1:0] cnt_next;

    // Abort wins over acceptance; no word is taken once the window is full.
    assign accept = (state == S_RUN) && !abort_i && data_valid_i && (word_cnt != len_q);

    // Predecessor of each lane: lane k-1 of the same word, or for lane 0 the last
    // lane of the previous accepted word.
    assign prev_vec = {s1_data[(LANES-1)*W-1:0], s1_prev_last};

    always_comb begin
        lane_err = '0;
        for (int k = 0; k < LANES; k++) begin
            if (mode_q) begin
                lane_err[k] = (s1_data[k*W +: W] != pattern_q);
            end else if ((k == 0) && !s1_has_prev) begin
                lane_err[k] = 1'b0;
            end else begin
                lane_err[k] = (s1_data[k*W +: W] != W'(prev_vec[k*W +: W] + step_q));
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int k = 0; k < LANES; k++) begin
            pop = pop + PCW'(s2_err[k]);
        end
    end

    // Saturating add: widen, then clamp to all-ones on any carry out.
    assign sum_ext  = {{PCW{1'b0}}, err_cnt_o} + {{CNT_WIDTH{1'b0}}, pop};
    assign cnt_next = (|sum_ext[SUMW-1:CNT_WIDTH]) ? {CNT_WIDTH{1'b1}} : sum_ext[CNT_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            mode_q           <= 1'b0;
            step_q           <= '0;
            pattern_q        <= '0;
            len_q            <= '0;
            word_cnt         <= '0;
            drain_cnt        <= 1'b0;
            last_lane        <= '0;
            have_prev        <= 1'b0;
            s1_valid         <= 1'b0;
            s1_data          <= '0;
            s1_idx           <= '0;
            s1_prev_last     <= '0;
            s1_has_prev      <= 1'b0;
            s2_valid         <= 1'b0;
            s2_err           <= '0;
            s2_idx           <= '0;
            found            <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            err_cnt_o        <= '0;
            lane_err_mask_o  <= '0;
            first_err_word_o <= '0;
        end else begin
            done_o <= 1'b0;

            // Stage 1
            s1_valid <= accept;
            if (accept) begin
                s1_data      <= adc_data_i;
                s1_idx       <= word_cnt;
                s1_prev_last <= last_lane;
                s1_has_prev  <= have_prev;
                last_lane    <= adc_data_i[W*LANES-1 -: W];
                have_prev    <= 1'b1;
                word_cnt     <= word_cnt + CNT_WIDTH'(1);
            end

            // Stage 2
            s2_valid <= s1_valid;
            s2_err   <= s1_valid ? lane_err : '0;
            s2_idx   <= s1_idx;

            // Stage 3
            if (s2_valid) begin
                err_cnt_o       <= cnt_next;
                lane_err_mask_o <= lane_err_mask_o | s2_err;
                if ((|s2_err) && !found) begin
                    first_err_word_o <= s2_idx;
                    found            <= 1'b1;
                end
            end

            // Control; assignments here override the pipeline defaults above.
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q           <= mode_i;
                        step_q           <= step_i;
                        pattern_q        <= pattern_i;
                        len_q            <= (window_len_i == '0) ? CNT_WIDTH'(1) : window_len_i;
                        word_cnt         <= '0;
                        have_prev        <= 1'b0;
                        found            <= 1'b0;
                        err_cnt_o        <= '0;
                        lane_err_mask_o  <= '0;
                        first_err_word_o <= '0;
                        pass_o           <= 1'b0;
                        busy_o           <= 1'b1;
                        state            <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort_i) begin
                        state    <= S_IDLE;
                        busy_o   <= 1'b0;
                        pass_o   <= 1'b0;
                        s1_valid <= 1'b0;
                        s2_valid <= 1'b0;
                    end else if (word_cnt == len_q) begin
                        // Last word went into stage 1 on the previous edge.
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (abort_i) begin
                        state    <= S_IDLE;
                        busy_o   <= 1'b0;
                        pass_o   <= 1'b0;
                        s1_valid <= 1'b0;
                        s2_valid <= 1'b0;
                    end else if (drain_cnt) begin
                        // Final accumulate landed on the previous edge.
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        pass_o <= (err_cnt_o == '0);
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_pattern_monitor.sv
// tb/tb_adc_pattern_monitor.sv - randomized self-checking bench for adc_pattern_monitor

module tb_adc_pattern_monitor;

    localparam int W     = 8;
    localparam int LANES = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1;
    logic                 data_valid_i = 1'b0;
    logic [W*LANES-1:0]   adc_data_i = '0;
    logic                 mode_i = 1'b0;
    logic [7:0]           step_i = '0;
    logic [7:0]           pattern_i = '0;
    logic                 start_i = 1'b0;
    logic                 abort_i = 1'b0;
    logic [15:0]          window_len_i = '0;

    logic                 busy_o, done_o, pass_o;
    logic [15:0]          err_cnt_o, first_err_word_o;
    logic [7:0]           lane_err_mask_o;
    logic                 busy4, done4, pass4;
    logic [3:0]           err_cnt4, first4;
    logic [7:0]           mask4;

    adc_pattern_monitor #(.ADC_DATA_WIDTH(8), .PARALLEL_PATH_NUM(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .data_valid_i(data_valid_i), .adc_data_i(adc_data_i),
        .mode_i(mode_i), .step_i(step_i), .pattern_i(pattern_i), .start_i(start_i),
        .abort_i(abort_i), .window_len_i(window_len_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .err_cnt_o(err_cnt_o), .lane_err_mask_o(lane_err_mask_o),
        .first_err_word_o(first_err_word_o)
    );

    adc_pattern_monitor #(.ADC_DATA_WIDTH(8), .PARALLEL_PATH_NUM(4), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .data_valid_i(data_valid_i), .adc_data_i(adc_data_i),
        .mode_i(mode_i), .step_i(step_i), .pattern_i(pattern_i), .start_i(start_i),
        .abort_i(abort_i), .window_len_i(window_len_i[3:0]), .busy_o(busy4), .done_o(done4),
        .pass_o(pass4), .err_cnt_o(err_cnt4), .lane_err_mask_o(mask4),
        .first_err_word_o(first4)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int edge_n = 0;

    // Reference model state
    int           s_edge    = -1;
    int           busy_end  = -1;
    int           done_edge = -1;
    bit           running   = 1'b0;
    bit           t_mode;
    logic [7:0]   t_step, t_pattern;
    int           t_len;
    logic [63:0]  words[$];
    logic [15:0]  e_cnt, e_first;
    logic [3:0]   e_cnt4;
    logic [7:0]   e_mask;
    logic         e_pass;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    endtask

    function automatic logic [63:0] ramp_word(input logic [7:0] first, input logic [7:0] step);
        logic [63:0] r;
        for (int k = 0; k < LANES; k++) r[k*8 +: 8] = 8'(first + step * k);
        return r;
    endfunction

    // Error statistics straight from the pattern rules over the accepted words.
    task automatic compute_expected();
        int cnt, fi;
        bit found, err;
        logic [63:0] cur;
        logic [7:0] prev_last, lane, want, m;
        cnt = 0; fi = 0; found = 0; prev_last = 0; m = 0;
        for (int w = 0; w < words.size(); w++) begin
            cur = words[w];
            for (int k = 0; k < LANES; k++) begin
                lane = cur[k*8 +: 8];
                if (t_mode) err = (lane != t_pattern);
                else if (k == 0) err = (w != 0) && (lane != 8'(prev_last + t_step));
                else begin
                    want = 8'(cur[(k-1)*8 +: 8] + t_step);
                    err  = (lane != want);
                end
                if (err) begin
                    cnt++;
                    m[k] = 1'b1;
                    if (!found) begin found = 1; fi = w; end
                end
            end
            prev_last = cur[63:56];
        end
        e_cnt   = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
        e_cnt4  = (cnt > 15) ? 4'hF : 4'(cnt);
        e_mask  = m;
        e_first = 16'(fi);
        e_pass  = (cnt == 0);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit eb, ed;
        eb = (s_edge >= 0) && (edge_n >= s_edge) && (edge_n < busy_end);
        ed = (done_edge >= 0) && (edge_n == done_edge);
        check("busy", busy_o, eb);
        check("done", done_o, ed);
        check("busy4", busy4, eb);
        check("done4", done4, ed);
        if (rst) begin
            check("rst_err", err_cnt_o, 0);
            check("rst_mask", lane_err_mask_o, 0);
            check("rst_first", first_err_word_o, 0);
            check("rst_pass", pass_o, 0);
        end else if (done_edge >= 0 && edge_n >= done_edge) begin
            check("err_cnt", err_cnt_o, e_cnt);
            check("mask", lane_err_mask_o, e_mask);
            check("first_err", first_err_word_o, e_first);
            check("pass", pass_o, e_pass);
            check("err_cnt4", err_cnt4, e_cnt4);
            check("mask4", mask4, e_mask);
            check("first4", first4, e_first[3:0]);
            check("pass4", pass4, e_pass);
        end else if (s_edge >= 0 && edge_n == s_edge) begin
            check("clr_err", err_cnt_o, 0);
            check("clr_mask", lane_err_mask_o, 0);
            check("clr_first", first_err_word_o, 0);
            check("clr_pass", pass_o, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_test(input bit m, input logic [7:0] st, input logic [7:0] pt, input int ln);
        mode_i = m; step_i = st; pattern_i = pt; window_len_i = 16'(ln);
        data_valid_i = 1'b0; start_i = 1'b1;
        tick();
        start_i   = 1'b0;
        s_edge    = edge_n;
        busy_end  = 1 << 30;
        done_edge = -1;
        t_mode = m; t_step = st; t_pattern = pt;
        t_len  = (ln == 0) ? 1 : ln;
        words.delete();
        running = 1'b1;
    endtask

    // One cycle of input; configuration and start are scrambled while a test
    // is running because they must have no effect.
    task automatic send(input bit v, input logic [63:0] d);
        data_valid_i = v;
        adc_data_i   = d;
        if (running) begin
            mode_i       = 1'($urandom);
            step_i       = 8'($urandom);
            pattern_i    = 8'($urandom);
            window_len_i = 16'($urandom);
            start_i      = ($urandom % 8 == 0);
        end
        tick();
        start_i = 1'b0;
        data_valid_i = 1'b0;
        if (running && v && words.size() < t_len) begin
            words.push_back(d);
            if (words.size() == t_len) begin
                running   = 1'b0;
                busy_end  = edge_n + 3;
                done_edge = edge_n + 3;
                compute_expected();
            end
        end
    endtask

    task automatic junk(input int n);
        for (int i = 0; i < n; i++) send(1'($urandom), {$urandom, $urandom});
    endtask

    task automatic do_abort();
        abort_i = 1'b1;
        tick();
        abort_i   = 1'b0;
        running   = 1'b0;
        busy_end  = edge_n;
        done_edge = -1;
        check("abort_pass", pass_o, 0);
    endtask

    initial begin
        logic [63:0] w;
        logic [7:0]  base;
        bit          m, v;
        logic [7:0]  st, pt;
        int          ln, guard, lane;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("init_busy", busy_o, 0);
        check("init_err", err_cnt_o, 0);

        // Continuous ramp from 0xFC with wrap, no errors
        start_test(0, 8'd1, 8'h00, 4);
        for (int i = 0; i < 4; i++) send(1, ramp_word(8'(8'hFC + 8 * i), 8'd1));
        repeat (3) tick();
        check("r24_done", done_o, 1);
        check("r24_pass", pass_o, 1);
        check("r24_err", err_cnt_o, 0);
        junk(2);

        // Lane 5 of word 2 offset by one -> lanes 5 and 6 flagged
        start_test(0, 8'd1, 8'h00, 4);
        for (int i = 0; i < 4; i++) begin
            w = ramp_word(8'(8'hFC + 8 * i), 8'd1);
            if (i == 2) w[47:40] = w[47:40] + 8'd1;
            send(1, w);
        end
        repeat (3) tick();
        check("r25_err", err_cnt_o, 2);
        check("r25_mask", lane_err_mask_o, 8'h60);
        check("r25_first", first_err_word_o, 2);
        check("r25_pass", pass_o, 0);
        junk(2);

        // Fixed pattern with gaps; invalid words carry wrong data
        start_test(1, 8'd0, 8'hA5, 3);
        send(1, {8{8'hA5}});
        send(0, 64'h0);
        send(1, 64'h0);
        send(0, 64'h0);
        send(0, 64'h1234);
        send(1, {8{8'hA5}});
        repeat (3) tick();
        check("r26_err", err_cnt_o, 8);
        check("r26_mask", lane_err_mask_o, 8'hFF);
        check("r26_first", first_err_word_o, 1);
        junk(2);

        // All lanes wrong for 3 words: 24 errors, 4-bit counter saturates
        start_test(1, 8'd0, 8'h3C, 3);
        for (int i = 0; i < 3; i++) send(1, 64'h0);
        repeat (3) tick();
        check("r27_err16", err_cnt_o, 24);
        check("r27_err4", err_cnt4, 4'hF);
        check("r27_pass4", pass4, 0);
        junk(2);

        // Abort after two words, then a clean test
        start_test(0, 8'd1, 8'h00, 4);
        send(1, ramp_word(8'h00, 8'd1));
        send(1, ramp_word(8'h08, 8'd1));
        do_abort();
        junk(5);
        start_test(0, 8'd3, 8'h00, 2);
        send(1, ramp_word(8'h10, 8'd3));
        send(1, ramp_word(8'h28, 8'd3));
        repeat (3) tick();
        check("r28_done", done_o, 1);
        check("r28_pass", pass_o, 1);
        check("r28_err", err_cnt_o, 0);
        check("r28_mask", lane_err_mask_o, 0);
        junk(2);

        // Reset while draining
        start_test(1, 8'd0, 8'hA5, 1);
        send(1, 64'h0);
        tick();
        tick();
        check("r29_busy_before", busy_o, 1);
        check("r29_err_before", err_cnt_o, 8);
        #2;
        rst = 1'b1;
        s_edge = -1; done_edge = -1; running = 1'b0;
        #1;
        check("r29_busy", busy_o, 0);
        check("r29_done", done_o, 0);
        check("r29_err", err_cnt_o, 0);
        check("r29_mask", lane_err_mask_o, 0);
        check("r29_first", first_err_word_o, 0);
        repeat (2) tick();
        rst = 1'b0;
        junk(6);

        // Randomized tests
        for (int t = 0; t < 25; t++) begin
            m  = 1'($urandom);
            st = 8'($urandom);
            pt = 8'($urandom);
            ln = $urandom_range(0, 6);
            start_test(m, st, pt, ln);
            base  = 8'($urandom);
            guard = 0;
            while (running && guard < 60) begin
                v = ($urandom % 3 != 0) || (guard > 40);
                w = m ? {8{pt}} : ramp_word(base, st);
                if ($urandom % 5 == 0) begin
                    lane = $urandom_range(0, 7);
                    w[lane*8 +: 8] = w[lane*8 +: 8] ^ 8'($urandom_range(1, 255));
                end
                if (!v) w = {$urandom, $urandom};
                send(v, w);
                if (v) base = 8'(base + 8 * st);
                guard++;
            end
            if (running) check("rand_window_ended", 0, 1);
            junk(4);
        end

        junk(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adc_pattern_monitor.md
ADC_PATTERN_MONITOR -- requirements
Module: adc_pattern_monitor

Interface
REQ-001 SHALL have parameter ADC_DATA_WIDTH, default 8: bits per sample.
REQ-002 SHALL have parameter PARALLEL_PATH_NUM, default 4: paths per core; LANES = 2*PARALLEL_PATH_NUM samples per word.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of error counter and window length.
REQ-004 SHALL have ports: clk in 1 sole clock; rst in 1 asynchronous active-high reset.
REQ-005 SHALL have ports: data_valid_i in 1 word qualifier; adc_data_i in ADC_DATA_WIDTH*LANES word, lane i at bits [(i+1)*W-1:i*W], lane 0 oldest.
REQ-006 SHALL have ports: mode_i in 1 (0 ramp, 1 fixed pattern); step_i in ADC_DATA_WIDTH ramp increment; pattern_i in ADC_DATA_WIDTH fixed value.
REQ-007 SHALL have ports: start_i in 1 test request pulse; abort_i in 1 cancel; window_len_i in CNT_WIDTH words per test.
REQ-008 SHALL have ports: busy_o out 1; done_o out 1 one-cycle pulse; pass_o out 1; err_cnt_o out CNT_WIDTH; lane_err_mask_o out LANES sticky per-lane flags; first_err_word_o out CNT_WIDTH index of first bad word.

Function
REQ-009 SHALL implement states IDLE, RUN, DRAIN, DONE; busy_o high in RUN and DRAIN only.
REQ-010 SHALL, in IDLE on start_i=1, latch mode_i, step_i, pattern_i, window_len_i (0 treated as 1), clear err_cnt_o, lane_err_mask_o, first_err_word_o, pass_o, word counter, and enter RUN next edge.
REQ-011 SHALL ignore start_i outside IDLE; mode/step/pattern/window changes during a test SHALL have no effect.
REQ-012 SHALL, in RUN, accept a word on each edge with data_valid_i=1; words with data_valid_i=0 SHALL not be counted or checked.
REQ-013 SHALL, after window_len words accepted, enter DRAIN for exactly 2 cycles, then DONE for 1 cycle with done_o=1, then IDLE; data in DRAIN/DONE ignored.
REQ-014 SHALL pipeline in 3 stages: input register, per-lane compare, accumulate; done_o asserted on the 3rd edge after the edge sampling the last word.
REQ-015 Ramp mode: lane k (k>=1) SHALL be in error unless lane k == lane k-1 + step, modulo 2^ADC_DATA_WIDTH (wrap 255+1=0 for W=8 is correct).
REQ-016 Ramp mode: lane 0 SHALL be in error unless lane 0 == last lane of previous accepted word + step; lane 0 of first word of a test SHALL never be flagged.
REQ-017 Fixed mode: every lane SHALL be in error unless equal to latched pattern.
REQ-018 SHALL add the count of erroring lanes per word (0..LANES) to err_cnt_o, saturating at all-ones, no wrap.
REQ-019 SHALL OR each lane error into lane_err_mask_o; SHALL load first_err_word_o (0-based accepted-word index) only on the first erroneous word of a test.
REQ-020 SHALL set pass_o on the edge done_o rises: 1 iff err_cnt_o==0; pass_o, err_cnt_o, mask, first_err_word_o SHALL hold until next start.
REQ-021 SHALL, on abort_i=1 in RUN or DRAIN, go to IDLE next edge, no done_o, pass_o=0, counters hold last values; abort has priority over word acceptance; abort in IDLE/DONE ignored.

Reset
REQ-022 SHALL, with rst=1, asynchronously force IDLE, all pipeline registers 0, busy_o=0, done_o=0, pass_o=0, err_cnt_o=0, lane_err_mask_o=0, first_err_word_o=0.
REQ-023 SHALL, on rst mid-test, discard the test; after release, only a new start_i begins a test.

Verification
REQ-024 W=8, LANES=8, ramp step 1, window 4, continuous ramp starting 0xFC across 4 words -> done_o 3 edges after last word, pass_o=1, err_cnt_o=0.
REQ-025 Same, lane 5 of word 2 corrupted (+1 offset) -> err_cnt_o=2 (lanes 5,6), lane_err_mask_o=0x60, first_err_word_o=2, pass_o=0.
REQ-026 Fixed mode pattern 0xA5, window 3, word 1 all lanes 0x00, data_valid_i toggling -> only valid words counted, err_cnt_o=8, mask=0xFF.
REQ-027 CNT_WIDTH=4, fixed mode, window 3, all lanes wrong -> err_cnt_o saturates at 15.
REQ-028 abort_i in RUN after 2 words, then start_i -> no done_o on abort, pass_o=0; new test results cleared and correct.
REQ-029 rst pulsed during DRAIN -> all outputs 0 immediately, no done_o, IDLE after release.
